// File: rtl/mmio_bridge_pkg.sv
// ===========================================================================
// mmio_bridge_pkg : shared types and constants for the MMIO bridge blocks
// Revision 1.0
// ===========================================================================
`default_nettype none

package mmio_bridge_pkg;

  localparam int MMIO_RSP_FIFO_DEPTH = 256;

  typedef struct packed {
    logic [9:0]  tag;
    logic [13:0] length;
    logic [15:0] req_id;
    logic [23:0] low_addr;
  } rd_req_t;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_ISSUE = 1'b1
  } rd_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_up_down_cnt.sv
// ===========================================================================
// mmio_up_down_cnt : saturating up/down counter, 0..MAX_VAL
// Revision 1.0
// ===========================================================================
`default_nettype none

module mmio_up_down_cnt #(
  parameter int WIDTH   = 9,
  parameter int MAX_VAL = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(MAX_VAL);

  // Coincident inc and dec cancel; a decrement at zero is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && (count != CAP)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_mmio_rd_scheduler.sv
// ===========================================================================
// axis_mmio_rd_scheduler : credit-limited MMIO read issue to AVMM with Tx
// sideband; optional response timeout via macro MMIO_RD_TIMEOUT_EN.
// Revision 1.0
// ===========================================================================
`default_nettype none

module axis_mmio_rd_scheduler
  import mmio_bridge_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH = 20,
  parameter int AVMM_DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 64,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AVMM_ADDR_WIDTH-1:0] req_addr,
  input  logic [9:0]                 req_tag,
  input  logic [13:0]                req_length,
  input  logic [15:0]                req_id,
  input  logic [23:0]                req_low_addr,
  output logic                       avmm_read,
  output logic [AVMM_ADDR_WIDTH-1:0] avmm_address,
  input  logic                       avmm_waitrequest,
  input  logic                       avmm_readdatavalid,
  input  logic [AVMM_DATA_WIDTH-1:0] avmm_readdata,
  output logic                       s2m_readdatavalid,
  output logic [AVMM_DATA_WIDTH-1:0] s2m_readdata,
  output logic                       tlp_rd_strb,
  output logic [9:0]                 tlp_rd_tag,
  output logic [13:0]                tlp_rd_length,
  output logic [15:0]                tlp_rd_req_id,
  output logic [23:0]                tlp_rd_low_addr,
  input  logic                       cpl_sent,
  output logic                       timeout_err,
  output logic [8:0]                 credit_cnt
);

  generate
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MMIO_RSP_FIFO_DEPTH) begin : g_bad_max
      $error("MAX_OUTSTANDING must lie in 1..MMIO_RSP_FIFO_DEPTH");
    end
    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 16..65536");
    end
  endgenerate

  rd_sched_state_t state;
  rd_req_t         req_q;
  logic [8:0]      pend_cnt;
  logic            accept;
  logic            inject;

  assign accept = req_valid && (credit_cnt < 9'(MAX_OUTSTANDING));

  // Strobe is tied to the AVMM acceptance cycle so the Tx tag FIFO is
  // always written before the matching response can reach it.
  assign tlp_rd_strb     = avmm_read && !avmm_waitrequest;
  assign tlp_rd_tag      = req_q.tag;
  assign tlp_rd_length   = req_q.length;
  assign tlp_rd_req_id   = req_q.req_id;
  assign tlp_rd_low_addr = req_q.low_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RD_IDLE;
      req_ready    <= 1'b0;
      avmm_read    <= 1'b0;
      avmm_address <= '0;
      req_q        <= '0;
    end else begin
      req_ready <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (accept) begin
            req_q.tag      <= req_tag;
            req_q.length   <= req_length;
            req_q.req_id   <= req_id;
            req_q.low_addr <= req_low_addr;
            avmm_address   <= req_addr;
            avmm_read      <= 1'b1;
            req_ready      <= 1'b1;
            state          <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!avmm_waitrequest) begin
            avmm_read <= 1'b0;
            state     <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  mmio_up_down_cnt #(.WIDTH(9), .MAX_VAL(MAX_OUTSTANDING)) u_credit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tlp_rd_strb),
    .dec   (cpl_sent),
    .count (credit_cnt)
  );

  mmio_up_down_cnt #(.WIDTH(9), .MAX_VAL(MAX_OUTSTANDING)) u_pend_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tlp_rd_strb),
    .dec   (s2m_readdatavalid),
    .count (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2m_readdatavalid <= 1'b0;
      s2m_readdata      <= '0;
    end else if (avmm_readdatavalid) begin
      s2m_readdatavalid <= 1'b1;
      s2m_readdata      <= avmm_readdata;
    end else if (inject) begin
      s2m_readdatavalid <= 1'b1;
      s2m_readdata      <= '1;
    end else begin
      s2m_readdatavalid <= 1'b0;
    end
  end

`ifdef MMIO_RD_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // A real response in the expiry cycle suppresses the synthetic one.
  assign inject = (pend_cnt != '0) && !avmm_readdatavalid &&
                  (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (avmm_readdatavalid || (pend_cnt == '0) || inject) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (inject) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign inject      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  pend_bounded: assert property (@(posedge clk) pend_cnt <= 9'(MAX_OUTSTANDING));

endmodule

`default_nettype wire

// File: tb/tb_axis_mmio_rd_scheduler.sv
// ===========================================================================
// tb_axis_mmio_rd_scheduler : directed + random bench with behavioural model
// Revision 1.0
// ===========================================================================
`default_nettype none

module tb_axis_mmio_rd_scheduler;

  localparam int AW   = 20;
  localparam int DW   = 64;
  localparam int MAXO = 4;
  localparam int TO   = 32;
`ifdef MMIO_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [9:0]    req_tag = '0;
  logic [13:0]   req_length = '0;
  logic [15:0]   req_id = '0;
  logic [23:0]   req_low_addr = '0;
  logic          avmm_read;
  logic [AW-1:0] avmm_address;
  logic          avmm_waitrequest = 1'b0;
  logic          avmm_readdatavalid = 1'b0;
  logic [DW-1:0] avmm_readdata = '0;
  logic          s2m_readdatavalid;
  logic [DW-1:0] s2m_readdata;
  logic          tlp_rd_strb;
  logic [9:0]    tlp_rd_tag;
  logic [13:0]   tlp_rd_length;
  logic [15:0]   tlp_rd_req_id;
  logic [23:0]   tlp_rd_low_addr;
  logic          cpl_sent = 1'b0;
  logic          timeout_err;
  logic [8:0]    credit_cnt;

  always #5 clk = ~clk;

  axis_mmio_rd_scheduler #(
    .AVMM_ADDR_WIDTH (AW),
    .AVMM_DATA_WIDTH (DW),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_tag            (req_tag),
    .req_length         (req_length),
    .req_id             (req_id),
    .req_low_addr       (req_low_addr),
    .avmm_read          (avmm_read),
    .avmm_address       (avmm_address),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_readdata      (avmm_readdata),
    .s2m_readdatavalid  (s2m_readdatavalid),
    .s2m_readdata       (s2m_readdata),
    .tlp_rd_strb        (tlp_rd_strb),
    .tlp_rd_tag         (tlp_rd_tag),
    .tlp_rd_length      (tlp_rd_length),
    .tlp_rd_req_id      (tlp_rd_req_id),
    .tlp_rd_low_addr    (tlp_rd_low_addr),
    .cpl_sent           (cpl_sent),
    .timeout_err        (timeout_err),
    .credit_cnt         (credit_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what the outputs must be in the cycle following each edge.
  bit            started = 1'b0;
  bit            m_busy, m_ready, m_rsp_v, m_terr;
  logic [AW-1:0] m_addr;
  logic [9:0]    m_tag;
  logic [13:0]   m_len;
  logic [15:0]   m_id;
  logic [23:0]   m_low;
  logic [63:0]   m_rsp_d;
  int            m_credits, m_pend, m_wait;

  always @(posedge clk) begin : model
    bit fire, take, inj;
    started = 1'b1;
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_rsp_v = 0; m_terr = 0;
      m_addr = '0; m_tag = '0; m_len = '0; m_id = '0; m_low = '0; m_rsp_d = '0;
      m_credits = 0; m_pend = 0; m_wait = 0;
    end else begin
      fire = m_busy && !avmm_waitrequest;
      take = !m_busy && req_valid && (m_credits < MAXO);
      inj  = 1'b0;
      if (TO_EN) begin
        if (m_pend > 0 && !avmm_readdatavalid) begin
          m_wait++;
          if (m_wait == TO) begin
            inj    = 1'b1;
            m_wait = 0;
          end
        end else begin
          m_wait = 0;
        end
      end
      if (fire && !cpl_sent) m_credits++;
      else if (!fire && cpl_sent && m_credits > 0) m_credits--;
      if (fire && !m_rsp_v) m_pend++;
      else if (!fire && m_rsp_v && m_pend > 0) m_pend--;
      if (avmm_readdatavalid) begin
        m_rsp_v = 1'b1; m_rsp_d = avmm_readdata;
      end else if (inj) begin
        m_rsp_v = 1'b1; m_rsp_d = '1; m_terr = 1'b1;
      end else begin
        m_rsp_v = 1'b0;
      end
      m_ready = take;
      if (take) begin
        m_busy = 1'b1; m_addr = req_addr; m_tag = req_tag;
        m_len = req_length; m_id = req_id; m_low = req_low_addr;
      end else if (fire) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk("req_ready", 64'(req_ready), 64'(m_ready));
      chk("avmm_read", 64'(avmm_read), 64'(m_busy));
      if (m_busy) chk("avmm_address", 64'(avmm_address), 64'(m_addr));
      chk("tlp_rd_strb", 64'(tlp_rd_strb), 64'(m_busy && !avmm_waitrequest));
      if (m_busy && !avmm_waitrequest) begin
        chk("tlp_rd_tag", 64'(tlp_rd_tag), 64'(m_tag));
        chk("tlp_rd_length", 64'(tlp_rd_length), 64'(m_len));
        chk("tlp_rd_req_id", 64'(tlp_rd_req_id), 64'(m_id));
        chk("tlp_rd_low_addr", 64'(tlp_rd_low_addr), 64'(m_low));
      end
      chk("s2m_readdatavalid", 64'(s2m_readdatavalid), 64'(m_rsp_v));
      if (m_rsp_v) chk("s2m_readdata", s2m_readdata, m_rsp_d);
      chk("credit_cnt", 64'(credit_cnt), 64'(m_credits));
      chk("timeout_err", 64'(timeout_err), 64'(m_terr));
    end
  end

  initial begin : stim
    int n_rd, n_strb, n_acc, addr_bad, extra;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_avmm_read", 64'(avmm_read), 64'd0);
    chk("rst_avmm_address", 64'(avmm_address), 64'd0);
    chk("rst_s2m_data", s2m_readdata, 64'd0);
    chk("rst_credit", 64'(credit_cnt), 64'd0);
    chk("rst_tlp_tag", 64'(tlp_rd_tag), 64'd0);

    // Single read
    tick();
    rst_n = 1'b1;
    req_valid = 1'b1; req_addr = 20'h00100; req_tag = 10'h02A;
    req_length = 14'd8; req_id = 16'h0100; req_low_addr = 24'h000100;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("single_req_ready", 64'(req_ready), 64'd1);
    chk("single_strb", 64'(tlp_rd_strb), 64'd1);
    chk("single_tag", 64'(tlp_rd_tag), 64'h2A);
    chk("single_addr", 64'(avmm_address), 64'h100);
    tick();
    @(negedge clk);
    chk("single_read_1cyc", 64'(avmm_read), 64'd0);
    chk("single_credit", 64'(credit_cnt), 64'd1);
    tick();
    avmm_readdatavalid = 1'b1; avmm_readdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    avmm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid", 64'(s2m_readdatavalid), 64'd1);
    chk("single_rsp_data", s2m_readdata, 64'hDEAD_BEEF_0123_4567);
    chk("single_credit_held", 64'(credit_cnt), 64'd1);
    cpl_sent = 1'b1;
    tick();
    cpl_sent = 1'b0;
    @(negedge clk);
    chk("single_credit_freed", 64'(credit_cnt), 64'd0);

    // Waitrequest stall
    tick();
    avmm_waitrequest = 1'b1; req_valid = 1'b1; req_addr = 20'h02468; req_tag = 10'h155;
    tick();
    req_valid = 1'b0;
    n_rd = 0; n_strb = 0; addr_bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (avmm_read) begin
        n_rd++;
        if (avmm_address !== 20'h02468) addr_bad++;
      end
      if (tlp_rd_strb) n_strb++;
      tick();
      if (k == 5) avmm_waitrequest = 1'b0;
    end
    chk("stall_read_cycles", 64'(n_rd), 64'd6);
    chk("stall_addr_stable", 64'(addr_bad), 64'd0);
    chk("stall_one_strb", 64'(n_strb), 64'd1);
    avmm_readdatavalid = 1'b1; cpl_sent = 1'b1;
    tick();
    avmm_readdatavalid = 1'b0; cpl_sent = 1'b0;
    tick();

    // Credit full
    req_valid = 1'b1; n_acc = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req_ready) n_acc++;
      tick();
    end
    chk("full_accepted", 64'(n_acc), 64'd4);
    chk("full_credit", 64'(credit_cnt), 64'd4);
    cpl_sent = 1'b1;
    tick();
    cpl_sent = 1'b0;
    tick();
    cpl_sent = 1'b1;
    @(negedge clk);
    chk("full_fifth_strb", 64'(tlp_rd_strb), 64'd1);
    tick();
    cpl_sent = 1'b0;
    @(negedge clk);
    chk("full_simul_credit", 64'(credit_cnt), 64'd3);
    tick();
    req_valid = 1'b0;
    tick();
    avmm_readdatavalid = 1'b1; cpl_sent = 1'b1;
    repeat (8) tick();
    avmm_readdatavalid = 1'b0; cpl_sent = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("drain_credit", 64'(credit_cnt), 64'd0);

    // Reset during ISSUE
    req_valid = 1'b1; tick(); req_valid = 1'b0; tick();
    avmm_waitrequest = 1'b1; req_valid = 1'b1; tick(); req_valid = 1'b0; tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstiss_avmm_read", 64'(avmm_read), 64'd0);
    chk("rstiss_credit", 64'(credit_cnt), 64'd0);
    chk("rstiss_req_ready", 64'(req_ready), 64'd0);
    avmm_readdatavalid = 1'b1; avmm_readdata = 64'h0000_0000_CAFE_F00D;
    tick();
    avmm_readdatavalid = 1'b0; avmm_waitrequest = 1'b0;
    @(negedge clk);
    chk("rstiss_late_rsp", 64'(s2m_readdatavalid), 64'd1);
    tick();
    @(negedge clk);
    chk("rstiss_pend", 64'(dut.pend_cnt), 64'd0);
    chk("rstiss_idle", 64'(avmm_read), 64'd0);

`ifdef MMIO_RD_TIMEOUT_EN
    // Timeout with no AVMM response
    req_valid = 1'b1; tick(); req_valid = 1'b0; tick();
    extra = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      @(negedge clk);
      if (k < TO && s2m_readdatavalid) extra++;
    end
    chk("to_no_early", 64'(extra), 64'd0);
    chk("to_inject_valid", 64'(s2m_readdatavalid), 64'd1);
    chk("to_inject_data", s2m_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to_err", 64'(timeout_err), 64'd1);
    repeat (2) tick();
    @(negedge clk);
    chk("to_pend_zero", 64'(dut.pend_cnt), 64'd0);

    // Timeout collision: real response on the expiry cycle
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 1'b1; tick(); req_valid = 1'b0; tick();
    repeat (TO - 1) tick();
    avmm_readdatavalid = 1'b1; avmm_readdata = 64'h1234;
    tick();
    avmm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("coll_valid", 64'(s2m_readdatavalid), 64'd1);
    chk("coll_data", s2m_readdata, 64'h1234);
    chk("coll_err", 64'(timeout_err), 64'd0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      @(negedge clk);
      if (s2m_readdatavalid) extra++;
    end
    chk("coll_no_inject", 64'(extra), 64'd0);
    chk("coll_err_late", 64'(timeout_err), 64'd0);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    for (int k = 0; k < 1500; k++) begin
      tick();
      req_valid          = ($urandom_range(0, 1) == 1);
      req_addr           = AW'($urandom);
      req_tag            = 10'($urandom);
      req_length         = 14'($urandom);
      req_id             = 16'($urandom);
      req_low_addr       = 24'($urandom);
      avmm_waitrequest   = ($urandom_range(0, 9) < 3);
      avmm_readdatavalid = ($urandom_range(0, 3) == 0);
      avmm_readdata      = {$urandom, $urandom};
      cpl_sent           = ($urandom_range(0, 3) == 0);
    end
    tick();
    req_valid = 1'b0; avmm_readdatavalid = 1'b0; cpl_sent = 1'b0; avmm_waitrequest = 1'b0;
    repeat (3) tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
